// File: rtl/portal_indication_arbiter.sv
// rtl/portal_indication_arbiter.sv - round-robin arbiter sharing one portal indication channel between sources
//
// Purpose:
//   Grants whole messages from NUM_SRC indication sources round-robin onto a
//   single indication channel. Each granted message goes out as one header word
//   {length[31:16], method[15:0]} and then its payload words. Messages are never
//   interleaved.
//
// Ports:
//   CLK          clock, all logic on the rising edge
//   RST          synchronous active-high reset
//   src_valid    per-source message present / current payload word valid
//   src_len      per-source payload length (LEN_W bits each), stable while valid
//   src_data     per-source current payload word (32 bits each)
//   src_deq      per-source one-cycle pop of the current payload word
//   ind_data     word presented to the host (0 when not valid)
//   ind_valid    ind_data valid
//   ind_deq      host consumes ind_data this cycle
//   busy         a message is granted
//   intr_status  indication interrupt status (= ind_valid)
//   intr_channel grant+1 while intr_status, else 0

module portal_indication_arbiter #(
    parameter int NUM_SRC = 2,
    parameter int LEN_W   = 4
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [NUM_SRC-1:0]         src_valid,
    input  logic [NUM_SRC*LEN_W-1:0]   src_len,
    input  logic [NUM_SRC*32-1:0]      src_data,
    output logic [NUM_SRC-1:0]         src_deq,
    output logic [31:0]                ind_data,
    output logic                       ind_valid,
    input  logic                       ind_deq,
    output logic                       busy,
    output logic                       intr_status,
    output logic [31:0]                intr_channel
);

    localparam int GW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_HEADER  = 2'd1,
        S_PAYLOAD = 2'd2
    } state_t;

    state_t             r_state;
    logic [GW-1:0]      r_rr_ptr;
    logic [GW-1:0]      r_grant;
    logic [LEN_W-1:0]   r_cnt;

    logic               w_found;
    logic [GW-1:0]      w_pick;
    logic [GW:0]        w_idx;
    logic [LEN_W-1:0]   w_pick_len;
    logic               w_sel_valid;
    logic [31:0]        w_sel_data;
    logic               w_xfer;
    logic [GW-1:0]      w_next_ptr;

    // Round-robin scan starting at r_rr_ptr; the extra bit of w_idx lets the
    // wrap be done with one subtraction for any NUM_SRC.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            w_idx = {1'b0, r_rr_ptr} + (GW+1)'(k);
            if (w_idx >= (GW+1)'(NUM_SRC)) begin
                w_idx = w_idx - (GW+1)'(NUM_SRC);
            end
            if (!w_found && src_valid[w_idx[GW-1:0]]) begin
                w_found = 1'b1;
                w_pick  = w_idx[GW-1:0];
            end
        end
    end

    assign w_pick_len  = src_len[int'(w_pick)*LEN_W +: LEN_W];
    assign w_sel_valid = src_valid[r_grant];
    assign w_sel_data  = src_data[int'(r_grant)*32 +: 32];
    assign w_next_ptr  = (r_grant == GW'(NUM_SRC-1)) ? '0 : r_grant + 1'b1;

    // Outputs follow the state directly; in PAYLOAD the granted source's
    // valid/data pass straight through so a source stall drops ind_valid at once.
    always_comb begin
        ind_valid    = 1'b0;
        ind_data     = '0;
        src_deq      = '0;
        case (r_state)
            S_HEADER: begin
                ind_valid = 1'b1;
                ind_data  = {16'(r_cnt), 16'(r_grant)};
            end
            S_PAYLOAD: begin
                ind_valid = w_sel_valid;
                ind_data  = w_sel_valid ? w_sel_data : '0;
                src_deq[r_grant] = w_sel_valid && ind_deq;
            end
            default: begin
                ind_valid = 1'b0;
            end
        endcase
        busy         = (r_state != S_IDLE);
        intr_status  = ind_valid;
        intr_channel = ind_valid ? (32'(r_grant) + 32'd1) : '0;
    end

    assign w_xfer = ind_valid && ind_deq;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= S_IDLE;
            r_rr_ptr <= '0;
            r_grant  <= '0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_grant <= w_pick;
                        r_cnt   <= w_pick_len;
                        r_state <= S_HEADER;
                    end
                end
                S_HEADER: begin
                    if (w_xfer) begin
                        if (r_cnt == '0) begin
                            r_state  <= S_IDLE;
                            r_rr_ptr <= w_next_ptr;
                        end else begin
                            r_state <= S_PAYLOAD;
                        end
                    end
                end
                S_PAYLOAD: begin
                    if (w_xfer) begin
                        r_cnt <= r_cnt - 1'b1;
                        if (r_cnt == LEN_W'(1)) begin
                            r_state  <= S_IDLE;
                            r_rr_ptr <= w_next_ptr;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_portal_indication_arbiter.sv
// tb/tb_portal_indication_arbiter.sv - self-checking bench for portal_indication_arbiter

module tb_portal_indication_arbiter;

    localparam int N  = 2;
    localparam int LW = 4;

    logic               CLK = 1'b0;
    logic               RST;
    logic [N-1:0]       src_valid;
    logic [N*LW-1:0]    src_len;
    logic [N*32-1:0]    src_data;
    logic [N-1:0]       src_deq;
    logic [31:0]        ind_data;
    logic               ind_valid;
    logic               ind_deq;
    logic               busy;
    logic               intr_status;
    logic [31:0]        intr_channel;

    portal_indication_arbiter #(.NUM_SRC(N), .LEN_W(LW)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .src_valid    (src_valid),
        .src_len      (src_len),
        .src_data     (src_data),
        .src_deq      (src_deq),
        .ind_data     (ind_data),
        .ind_valid    (ind_valid),
        .ind_deq      (ind_deq),
        .busy         (busy),
        .intr_status  (intr_status),
        .intr_channel (intr_channel)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Source side: queued messages (lengths) and their payload words.
    int          s_lens  [N][$];
    logic [31:0] s_words [N][$];

    // Expected host-visible stream.
    logic [31:0] e_word[$];
    int          e_src[$];
    bit          e_pay[$];

    logic [31:0] vpat;
    int          pulses;
    int          xfers;
    logic        g_busy;
    logic        g_valid;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_all();
        for (int i = 0; i < N; i++) begin
            s_lens[i].delete();
            s_words[i].delete();
        end
        e_word.delete();
        e_src.delete();
        e_pay.delete();
    endtask

    task automatic load_msg(input int s, input int len, input logic [31:0] base);
        s_lens[s].push_back(len);
        for (int k = 0; k < len; k++) s_words[s].push_back(base + 32'(k));
    endtask

    // Whole-message round-robin order: next message comes from the first source
    // with work at or after the one following the last served source.
    task automatic build_expected(input int start_ptr);
        int mi[N];
        int wi[N];
        int ptr;
        int pick;
        int len;
        ptr = start_ptr;
        for (int i = 0; i < N; i++) begin
            mi[i] = 0;
            wi[i] = 0;
        end
        forever begin
            pick = -1;
            for (int k = 0; k < N; k++) begin
                if (pick < 0 && mi[(ptr + k) % N] < s_lens[(ptr + k) % N].size()) pick = (ptr + k) % N;
            end
            if (pick < 0) break;
            len = s_lens[pick][mi[pick]];
            e_word.push_back({16'(len), 16'(pick)});
            e_src.push_back(pick);
            e_pay.push_back(1'b0);
            for (int k = 0; k < len; k++) begin
                e_word.push_back(s_words[pick][wi[pick] + k]);
                e_src.push_back(pick);
                e_pay.push_back(1'b1);
            end
            wi[pick] += len;
            mi[pick]++;
            ptr = (pick + 1) % N;
        end
    endtask

    task automatic drive(input bit deq, input bit stall);
        for (int i = 0; i < N; i++) begin
            bit has;
            bit st;
            has = s_lens[i].size() > 0;
            st  = stall && e_pay.size() > 0 && e_pay[0] && e_src[0] == i;
            src_valid[i] = has && !st;
            src_len[i*LW +: LW] = has ? LW'(s_lens[i][0]) : '0;
            src_data[i*32 +: 32] = (s_words[i].size() > 0) ? s_words[i][0] : 32'hDEAD_0000 + 32'(i);
        end
        ind_deq = deq;
    endtask

    task automatic cycle(input bit deq, input bit stall);
        bit          xfer;
        bit          in_pay;
        logic [N-1:0] exp_deq;
        int          s;
        drive(deq, stall);
        @(negedge CLK);
        in_pay  = e_pay.size() > 0 && e_pay[0];
        g_busy  = busy;
        g_valid = ind_valid;
        vpat    = {vpat[30:0], ind_valid};
        pulses += $countones(src_deq);
        if (in_pay) begin
            chk("payload_valid", 32'(ind_valid), 32'(!stall));
            chk("payload_busy", 32'(busy), 32'd1);
        end
        if (!ind_valid) begin
            chk("idle_data", ind_data, 32'd0);
            chk("idle_chan", intr_channel, 32'd0);
        end else if (e_word.size() == 0) begin
            chk("spurious_valid", 32'(ind_valid), 32'd0);
        end else begin
            chk("data", ind_data, e_word[0]);
            chk("chan", intr_channel, 32'(e_src[0] + 1));
        end
        xfer = ind_valid && deq && e_word.size() > 0;
        exp_deq = '0;
        if (xfer && in_pay) exp_deq[e_src[0]] = 1'b1;
        chk("src_deq", 32'(src_deq), 32'(exp_deq));
        @(posedge CLK);
        #1;
        if (xfer) begin
            xfers++;
            s = e_src[0];
            void'(e_word.pop_front());
            void'(e_src.pop_front());
            void'(e_pay.pop_front());
            if (in_pay) void'(s_words[s].pop_front());
            if (e_pay.size() == 0 || !e_pay[0]) void'(s_lens[s].pop_front());
        end
    endtask

    task automatic run_until_empty(input int deq_pct, input int stall_pct, input int max_cyc);
        int n;
        n = 0;
        while (e_word.size() > 0 && n < max_cyc) begin
            cycle($urandom_range(99) < deq_pct, $urandom_range(99) < stall_pct);
            n++;
        end
        chk("drain_timeout", 32'(e_word.size()), 32'd0);
    endtask

    task automatic do_reset(input int cyc);
        RST = 1'b1;
        drive(1'b1, 1'b0);
        repeat (cyc) begin
            @(negedge CLK);
            @(posedge CLK);
            #1;
        end
        RST = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1; src_valid = '0; src_len = '0; src_data = '0; ind_deq = 1'b0;
        vpat = '0; pulses = 0; xfers = 0; g_busy = 1'b0; g_valid = 1'b0;

        // Reset held two cycles with both sources requesting.
        clear_all();
        load_msg(0, 1, 32'h1000_0000);
        load_msg(1, 1, 32'h1100_0000);
        RST = 1'b1;
        drive(1'b1, 1'b0);
        repeat (2) begin
            @(negedge CLK);
            @(posedge CLK);
            #1;
            drive(1'b1, 1'b0);
            @(negedge CLK);
            chk("rst_valid", 32'(ind_valid), 32'd0);
            chk("rst_deq", 32'(src_deq), 32'd0);
            chk("rst_chan", intr_channel, 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_data", ind_data, 32'd0);
        end
        @(posedge CLK);
        #1;
        RST = 1'b0;
        build_expected(0);
        vpat = '0;
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0);
        chk("rst_latency", vpat[1:0], 2'b01);
        run_until_empty(100, 0, 50);

        // Single message from source 1.
        clear_all();
        do_reset(1);
        load_msg(1, 2, 32'hA5A5_0001);
        build_expected(0);
        vpat = '0; pulses = 0;
        run_until_empty(100, 0, 50);
        chk("single_pattern", vpat[3:0], 4'b0111);
        chk("single_pulses", 32'(pulses), 32'd2);
        cycle(1'b1, 1'b0);
        chk("single_done_busy", 32'(g_busy), 32'd0);

        // Round-robin with length-1 messages on both sources.
        clear_all();
        do_reset(1);
        for (int m = 0; m < 3; m++) begin
            load_msg(0, 1, 32'h2000_0000 + 32'(m));
            load_msg(1, 1, 32'h2100_0000 + 32'(m));
        end
        build_expected(0);
        vpat = '0;
        run_until_empty(100, 0, 100);
        chk("rr_pattern", vpat[17:0], 18'b011011011011011011);

        // Zero-length message.
        clear_all();
        do_reset(1);
        load_msg(0, 0, 32'h0);
        build_expected(0);
        vpat = '0; pulses = 0;
        run_until_empty(100, 0, 20);
        chk("zero_pattern", vpat[1:0], 2'b01);
        chk("zero_pulses", 32'(pulses), 32'd0);
        cycle(1'b1, 1'b0);
        chk("zero_done_busy", 32'(g_busy), 32'd0);

        // Source stall after word 1, then host stall.
        clear_all();
        do_reset(1);
        load_msg(1, 3, 32'h5000_0001);
        build_expected(0);
        pulses = 0; xfers = 0;
        for (int n = 0; n < 20 && xfers < 2; n++) cycle(1'b1, 1'b0);
        chk("stall_setup", 32'(xfers), 32'd2);
        repeat (4) cycle(1'b1, 1'b1);
        repeat (3) begin
            cycle(1'b0, 1'b0);
            chk("host_hold", ind_data, 32'h5000_0002);
        end
        run_until_empty(100, 0, 20);
        chk("stall_pulses", 32'(pulses), 32'd3);

        // Mid-message reset: finish source 0 first so the pointer moves to 1.
        clear_all();
        do_reset(1);
        load_msg(0, 1, 32'h6000_0000);
        build_expected(0);
        run_until_empty(100, 0, 20);
        load_msg(1, 3, 32'h6100_0000);
        build_expected(1);
        xfers = 0;
        for (int n = 0; n < 20 && xfers < 2; n++) cycle(1'b1, 1'b0);
        clear_all();
        load_msg(0, 2, 32'h6200_0000);
        load_msg(1, 1, 32'h6300_0000);
        do_reset(1);
        build_expected(0);
        cycle(1'b1, 1'b0);
        chk("midrst_busy", 32'(g_busy), 32'd0);
        chk("midrst_valid", 32'(g_valid), 32'd0);
        run_until_empty(100, 0, 50);

        // Randomized traffic with random host and source stalls.
        clear_all();
        do_reset(1);
        for (int i = 0; i < N; i++) begin
            int nm;
            nm = $urandom_range(6, 3);
            for (int m = 0; m < nm; m++) load_msg(i, $urandom_range(15, 0), $urandom);
        end
        build_expected(0);
        run_until_empty(70, 25, 4000);
        cycle(1'b1, 1'b0);
        chk("rand_done_busy", 32'(g_busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
